gshare_pht: RTL
===============

Name: gshare_pht

Overview:
- Pattern history table read by the fetch stage and written by branch resolution. It is the consumer of the global history shift register.
- Each prediction index is fetch PC bits [G_WIDTH+2:2] XOR globalHistory. The index selects one 2-bit saturating counter.
- The predictor returns a registered taken/not-taken prediction plus the index used. That index travels with the branch and comes back on the update port at resolve.

Parameters:
- G_WIDTH, 9: MSB index of history/index vectors; index width = G_WIDTH+1 (10 bits, 1024 entries).
- PC_WIDTH, 32: fetch PC width.
- INIT_CTR, 2'b01: counter value written to every entry during initialisation (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- globalHistory  in  G_WIDTH+1  current branch history, LSB = most recent outcome.
- fetchPC  in  PC_WIDTH  PC of the fetched branch.
- predictValid  in  1  prediction request.
- predictReady  out  1  high only in RUN state.
- predValid  out  1  prediction result valid (one cycle after acceptance).
- predTaken  out  1  counter[1] of the indexed entry.
- predIndex  out  G_WIDTH+1  index used for this prediction.
- updateValid  in  1  branch resolved.
- updateIndex  in  G_WIDTH+1  index returned with the resolved branch.
- updateTaken  in  1  actual branch outcome.

Behaviour:
- Reset (async assert, sync deassert):
  - state = INIT, sweep counter = 0, update pipeline invalid.
  - predictReady = 0, predValid = 0, predTaken = 0, predIndex = 0.
  - Table contents are don't-care until INIT completes.
- INIT state:
  - Writes INIT_CTR to entry[sweep] each cycle and increments sweep.
  - After entry 2^(G_WIDTH+1)-1 is written (1024 cycles), moves to RUN on the next edge.
  - predictValid and updateValid are ignored; no predValid is produced.
- RUN state: predictReady = 1; stays in RUN until reset.
- Predict:
  - Accepted at edge T when predictValid && predictReady.
  - idx = fetchPC[G_WIDTH+2:2] ^ globalHistory.
  - At T+1: predValid = 1, predIndex = idx, predTaken = ctr[idx][1].
  - predValid is a single-cycle pulse per accepted request; back-to-back requests give back-to-back results.
- Update: two-stage read-modify-write.
  - U0 (edge T): capture updateIndex/updateTaken and read the counter into the U1 register.
  - U1 (edge T+1): write the saturated value. Taken: 11 stays 11, else +1. Not taken: 00 stays 00, else -1.
  - The new value is visible to reads from T+2 onward.
- Hazards:
  - Back-to-back updates to the same index: U0 uses the U1 result being written that cycle, not the stale table value. Two taken updates on 01 must give 11.
  - Predict read and U1 write to the same index in the same cycle: the prediction returns the newly written value (write-first bypass).
  - Predict and update to different indices proceed independently; one table write per cycle, no stalls.
- Reset mid-operation: an in-flight prediction or update is discarded, predValid drops immediately, and INIT restarts from entry 0.
- Width rules: index arithmetic is pure bitwise XOR with no carry; PC bits [1:0] and bits above G_WIDTH+2 are unused.

Decomposition:
- Shared package (bp_pkg):
  - typedef ctr2_t (2-bit counter) and pht_idx_t.
  - constants CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11.
  - state enum {INIT, RUN}.
  - function sat_update(ctr2_t, taken) returning ctr2_t.
- One sub-module, pht_ram: 2^(G_WIDTH+1) x 2 array with one synchronous read port, one write port and write-first bypass, reused by the init sweep and the update writer.
- Control FSM, index hash and update pipeline live in gshare_pht.

Test Plan:
- Reset, hold predictValid = 1 -> predictReady = 0 for exactly 1024 cycles, then 1. First prediction of any PC/history -> predTaken = 0 (counter 01).
- fetchPC = 0x0000_0010, globalHistory = 0x3FF -> predIndex = 0x3FB, predValid one cycle after acceptance.
- Updates taken to index 0x005 on two consecutive cycles -> counter = 11; a later predict hashing to 0x005 gives predTaken = 1.
- Six taken updates to 0x0A0 -> counter saturates at 11. Then six not-taken -> saturates at 00, predTaken = 0, no wrap.
- Predict hashing to 0x011 in the same cycle that U1 writes 0x011 from 01 to 10 -> predTaken = 1 (bypass).
- Assert reset in RUN with a prediction and an update in flight -> predValid = 0 immediately, predictReady = 0 for 1024 cycles, all entries back to 01.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, counter constants and saturating update for the gshare predictor
package bp_pkg;

    localparam int PHT_G_WIDTH = 9;

    typedef logic [1:0]           ctr2_t;
    typedef logic [PHT_G_WIDTH:0] pht_idx_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pht_state_t;

    function automatic ctr2_t sat_update(input ctr2_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/pht_ram.sv
// rtl/pht_ram.sv - counter array with one synchronous read port and one write-first write port
module pht_ram
    import bp_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_addr,
    output ctr2_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  ctr2_t            wr_data
);

    ctr2_t mem [0:(1<<IDX_W)-1];

    // A read colliding with this cycle's write returns the value being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - gshare pattern history table: init sweep, registered prediction, RMW update
module gshare_pht
    import bp_pkg::*;
#(
    parameter int          G_WIDTH  = 9,
    parameter int          PC_WIDTH = 32,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [G_WIDTH:0]    globalHistory,
    input  logic [PC_WIDTH-1:0] fetchPC,
    input  logic                predictValid,
    output logic                predictReady,
    output logic                predValid,
    output logic                predTaken,
    output logic [G_WIDTH:0]    predIndex,
    input  logic                updateValid,
    input  logic [G_WIDTH:0]    updateIndex,
    input  logic                updateTaken
);

    localparam int               IDX_W    = G_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    pht_state_t       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             run;

    logic [IDX_W-1:0] pred_idx;
    logic             predict_fire;
    logic             update_fire;
    ctr2_t            pred_rd;

    logic             u1_valid;
    logic [IDX_W-1:0] u1_idx;
    logic             u1_taken;
    ctr2_t            u1_ctr;
    ctr2_t            u1_next;

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    ctr2_t            wr_data;

    logic             unused_pc;
    assign unused_pc = ^{fetchPC[1:0], fetchPC[PC_WIDTH-1:G_WIDTH+3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign run          = (state_q == RUN);
    assign predictReady = run;
    assign pred_idx     = fetchPC[G_WIDTH+2:2] ^ globalHistory;
    assign predict_fire = predictValid && run;
    assign update_fire  = updateValid && run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            predValid <= 1'b0;
            predIndex <= '0;
        end else begin
            predValid <= predict_fire;
            if (predict_fire) begin
                predIndex <= pred_idx;
            end
        end
    end

    // Counter bit 1 is the prediction; gated so it reads 0 whenever no result is presented.
    assign predTaken = predValid && (pred_rd >= CTR_WT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u1_valid <= 1'b0;
            u1_idx   <= '0;
            u1_taken <= 1'b0;
        end else begin
            u1_valid <= update_fire;
            if (update_fire) begin
                u1_idx   <= updateIndex;
                u1_taken <= updateTaken;
            end
        end
    end

    assign u1_next = sat_update(u1_ctr, u1_taken);

    // Init sweep owns the write port until RUN; afterwards only the U1 stage writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sweep_q;
        wr_data = INIT_CTR;
        if (!run) begin
            wr_en = 1'b1;
        end else if (u1_valid) begin
            wr_en   = 1'b1;
            wr_addr = u1_idx;
            wr_data = u1_next;
        end
    end

    // Two identically written copies give the predictor and the update RMW their own read port.
    pht_ram #(.IDX_W(IDX_W)) u_pred_ram (
        .clk     (clk),
        .rd_addr (pred_idx),
        .rd_data (pred_rd),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    pht_ram #(.IDX_W(IDX_W)) u_upd_ram (
        .clk     (clk),
        .rd_addr (updateIndex),
        .rd_data (u1_ctr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

endmodule
